// File: rtl/data_bus_ctrl.sv
// data_bus_ctrl: UR408 data-side bus controller, decodes LSU requests to RAM or I/O with wait states.
// Optional I/O timeout with sticky bus_err is built when BUS_TIMEOUT_EN is defined.
module data_bus_ctrl #(
   parameter int          RAM_AW     = 12,
   parameter int          RAM_WAIT   = 1,
   parameter logic [15:0] IO_BASE    = 16'hFF00,
   parameter int          IO_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       addr,
   input  logic [7:0]        wdata,
   input  logic              read,
   input  logic              write,
   output logic [7:0]        rdata,
   output logic              rdy,
   output logic              ram_ce,
   output logic              ram_we,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [7:0]        ram_wdata,
   input  logic [7:0]        ram_rdata,
   output logic              io_re,
   output logic              io_we,
   output logic [7:0]        io_addr,
   output logic [7:0]        io_wdata,
   input  logic [7:0]        io_rdata,
   input  logic              io_ack,
   input  logic              err_clr,
   output logic              bus_err
);
   typedef enum logic [2:0] {IDLE, RAM_ACC, RAM_WT, IO_ACC, DONE} state_t;
   state_t            r_state;
   logic              r_wr;
   logic [3:0]        r_wait;
   logic [7:0]        r_rdata;
   logic              r_rdy;
   logic              r_ram_ce;
   logic              r_ram_we;
   logic [RAM_AW-1:0] r_ram_addr;
   logic [7:0]        r_ram_wdata;
   logic              r_io_re;
   logic              r_io_we;
   logic [7:0]        r_io_addr;
   logic [7:0]        r_io_wdata;
   logic              w_req;
   logic              w_io;
   logic              w_to;
   assign w_req = read | write;
   assign w_io  = addr >= IO_BASE;
`ifdef BUS_TIMEOUT_EN
   localparam int TW = $clog2(IO_TIMEOUT + 1);
   logic [TW-1:0] r_to_cnt;
   logic          r_bus_err;
   // counter is zero in the first IO_ACC cycle, so a timeout fires in the IO_TIMEOUT-th one
   assign w_to = (r_state == IO_ACC) && !io_ack && (r_to_cnt == TW'(IO_TIMEOUT - 1));
   always_ff @(posedge clk) begin
      if (rst)
         r_to_cnt <= '0;
      else
         r_to_cnt <= (r_state == IO_ACC) ? r_to_cnt + 1'b1 : '0;
   end
   always_ff @(posedge clk) begin
      if (rst)
         r_bus_err <= 1'b0;
      else if (w_to)
         r_bus_err <= 1'b1;
      else if (err_clr)
         r_bus_err <= 1'b0;
   end
   assign bus_err = r_bus_err;
`else
   logic w_unused_err_clr;
   assign w_unused_err_clr = err_clr;
   assign w_to    = 1'b0;
   assign bus_err = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_wr        <= 1'b0;
         r_wait      <= '0;
         r_rdata     <= '0;
         r_rdy       <= 1'b0;
         r_ram_ce    <= 1'b0;
         r_ram_we    <= 1'b0;
         r_ram_addr  <= '0;
         r_ram_wdata <= '0;
         r_io_re     <= 1'b0;
         r_io_we     <= 1'b0;
         r_io_addr   <= '0;
         r_io_wdata  <= '0;
      end else begin
         r_rdy <= 1'b0;
         case (r_state)
            IDLE: if (w_req) begin
               r_wr        <= write;
               r_ram_addr  <= addr[RAM_AW-1:0];
               r_ram_wdata <= wdata;
               r_io_addr   <= addr[7:0];
               r_io_wdata  <= wdata;
               if (w_io) begin
                  r_io_we <= write;
                  r_io_re <= !write;
                  r_state <= IO_ACC;
               end else begin
                  r_ram_ce <= 1'b1;
                  r_ram_we <= write;
                  r_state  <= RAM_ACC;
               end
            end
            RAM_ACC: begin
               r_ram_ce <= 1'b0;
               r_ram_we <= 1'b0;
               r_wait   <= 4'(RAM_WAIT - 1);
               r_state  <= RAM_WT;
            end
            RAM_WT: if (r_wait == '0) begin
               if (!r_wr)
                  r_rdata <= ram_rdata;
               r_rdy   <= 1'b1;
               r_state <= DONE;
            end else
               r_wait <= r_wait - 1'b1;
            IO_ACC: if (io_ack || w_to) begin
               if (!r_wr)
                  r_rdata <= io_ack ? io_rdata : 8'hFF;
               r_io_re <= 1'b0;
               r_io_we <= 1'b0;
               r_rdy   <= 1'b1;
               r_state <= DONE;
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end
   assign rdata     = r_rdata;
   assign rdy       = r_rdy;
   assign ram_ce    = r_ram_ce;
   assign ram_we    = r_ram_we;
   assign ram_addr  = r_ram_addr;
   assign ram_wdata = r_ram_wdata;
   assign io_re     = r_io_re;
   assign io_we     = r_io_we;
   assign io_addr   = r_io_addr;
   assign io_wdata  = r_io_wdata;
endmodule

// File: tb/tb_data_bus_ctrl.sv
// tb_data_bus_ctrl: directed bench for data_bus_ctrl with a RAM model, an I/O responder and a rdy scoreboard.
module tb_data_bus_ctrl;
   localparam int IO_TIMEOUT = 16;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] addr = '0;
   logic [7:0]  wdata = '0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic [7:0]  rdata;
   logic        rdy;
   logic        ram_ce;
   logic        ram_we;
   logic [11:0] ram_addr;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata = '0;
   logic        io_re;
   logic        io_we;
   logic [7:0]  io_addr;
   logic [7:0]  io_wdata;
   logic [7:0]  io_rdata = '0;
   logic        io_ack = 1'b0;
   logic        err_clr = 1'b0;
   logic        bus_err;

   data_bus_ctrl #(.RAM_AW(12), .RAM_WAIT(1), .IO_BASE(16'hFF00), .IO_TIMEOUT(IO_TIMEOUT)) dut (
      .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .read(read), .write(write),
      .rdata(rdata), .rdy(rdy), .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .io_re(io_re), .io_we(io_we),
      .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata), .io_ack(io_ack),
      .err_clr(err_clr), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // one-wait synchronous RAM
   logic [7:0] mem [0:4095];
   always @(posedge clk)
      if (ram_ce) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else ram_rdata <= mem[ram_addr];
      end

   // I/O responder: acks in the io_lat-th strobe cycle, never when io_lat is 0
   int io_lat = 1;
   int io_cnt = 0;
   always @(negedge clk) begin
      if (io_re | io_we) begin
         io_cnt = io_cnt + 1;
         io_ack = (io_lat != 0) && (io_cnt == io_lat);
      end else begin
         io_cnt = 0;
         io_ack = 1'b0;
      end
   end

   typedef struct {logic [7:0] d; int c;} exp_t;
   exp_t sb[$];
   int n_ce, n_ram_we, n_io_re, n_io_we;
   logic [11:0] a_ram;
   logic [7:0]  d_ram, a_io, d_io;
   logic        last_err;

   always @(negedge clk) begin
      exp_t e;
      if (ram_ce) begin
         n_ce++;
         a_ram = ram_addr;
         d_ram = ram_wdata;
      end
      if (ram_we) n_ram_we++;
      if (io_re) n_io_re++;
      if (io_we) n_io_we++;
      if (io_re | io_we) begin
         a_io = io_addr;
         d_io = io_wdata;
      end
      if (rdy) begin
         last_err = bus_err;
         e = sb.size() != 0 ? sb.pop_front() : '{8'hxx, -1};
         chk("rdy_data", rdata, e.d);
         chk("rdy_cycle", cyc, e.c);
      end
   end

   logic [7:0] mdl_rdata = '0;
   logic [7:0] mdl_mem [logic [11:0]];

   task automatic access(input logic [15:0] a, input logic [7:0] d, input logic wr, input int lat);
      exp_t e;
      bit   got;
      @(negedge clk);
      n_ce = 0; n_ram_we = 0; n_io_re = 0; n_io_we = 0;
      io_lat = lat;
      addr = a; wdata = d; write = wr; read = !wr;
      if (a >= 16'hFF00) begin
         if (!wr) mdl_rdata = (lat == 0) ? 8'hFF : io_rdata;
         e.c = cyc + ((lat == 0) ? IO_TIMEOUT : lat) + 1;
      end else begin
         if (wr) mdl_mem[a[11:0]] = d;
         else mdl_rdata = mdl_mem[a[11:0]];
         e.c = cyc + 3;
      end
      e.d = mdl_rdata;
      sb.push_back(e);
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         got = rdy;
      end
      chk("rdy_seen", got, 1);
      read = 1'b0;
      write = 1'b0;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_rdy"}, rdy, 0);
      chk({tag, "_rdata"}, rdata, 0);
      chk({tag, "_ram_ce"}, ram_ce, 0);
      chk({tag, "_ram_we"}, ram_we, 0);
      chk({tag, "_io_re"}, io_re, 0);
      chk({tag, "_io_we"}, io_we, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      chk_idle_outputs("reset");
      chk("reset_ram_addr", ram_addr, 0);
      chk("reset_ram_wdata", ram_wdata, 0);
      chk("reset_io_addr", io_addr, 0);
      chk("reset_io_wdata", io_wdata, 0);
      chk("reset_bus_err", bus_err, 0);
      rst = 1'b0;

      access(16'h0123, 8'hA5, 1'b1, 0);
      chk("wr_ram_addr", a_ram, 12'h123);
      chk("wr_ram_wdata", d_ram, 8'hA5);
      chk("wr_ram_we_cycles", n_ram_we, 1);
      chk("wr_ram_ce_cycles", n_ce, 1);

      access(16'h0123, 8'h00, 1'b0, 0);
      chk("rd_ram_we_cycles", n_ram_we, 0);
      chk("rd_rdata", rdata, 8'hA5);

      access(16'h1123, 8'h00, 1'b0, 0);
      chk("alias_ram_addr", a_ram, 12'h123);

      access(16'hFF05, 8'h3C, 1'b1, 4);
      chk("io_wr_we_cycles", n_io_we, 4);
      chk("io_wr_re_cycles", n_io_re, 0);
      chk("io_wr_addr", a_io, 8'h05);
      chk("io_wr_data", d_io, 8'h3C);
      chk("io_wr_no_ram", n_ce, 0);
      chk("io_wr_rdata_kept", rdata, 8'hA5);

      io_rdata = 8'h5A;
      access(16'hFF10, 8'h00, 1'b0, 1);
      chk("io_rd_re_cycles", n_io_re, 1);
      chk("io_rd_addr", a_io, 8'h10);
      access(16'h0123, 8'h00, 1'b0, 0);
      chk("b2b_rdata", rdata, 8'hA5);
      chk("no_bus_err", bus_err, 0);

`ifdef BUS_TIMEOUT_EN
      access(16'hFF20, 8'h00, 1'b0, 0);
      chk("to_re_cycles", n_io_re, IO_TIMEOUT);
      chk("to_err_at_rdy", last_err, 1);
      @(negedge clk);
      chk("to_err_sticky", bus_err, 1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("to_err_cleared", bus_err, 0);
      err_clr = 1'b1;
      access(16'hFF21, 8'h00, 1'b0, 0);
      chk("to_vs_clr_err", last_err, 1);
      err_clr = 1'b0;
      @(negedge clk);
      chk("to_vs_clr_err_late", bus_err, 0);
      access(16'h0123, 8'h00, 1'b0, 0);
`endif

      // reset while waiting for RAM data
      @(negedge clk);
      addr = 16'h0123; read = 1'b1;
      @(negedge clk);
      chk("rst_ram_ce_seen", ram_ce, 1);
      @(negedge clk);
      rst = 1'b1; read = 1'b0;
      @(negedge clk);
      chk_idle_outputs("rst_ram");
      rst = 1'b0;
      mdl_rdata = '0;
      access(16'h0123, 8'h00, 1'b0, 0);
      chk("after_rst_ram", rdata, 8'hA5);

      // reset while an I/O read waits for an ack that never comes
      @(negedge clk);
      io_lat = 0;
      addr = 16'hFF30; read = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_io_re_seen", io_re, 1);
      rst = 1'b1; read = 1'b0;
      @(negedge clk);
      chk_idle_outputs("rst_io");
      chk("rst_io_bus_err", bus_err, 0);
      rst = 1'b0;
      mdl_rdata = '0;
      io_rdata = 8'hC3;
      access(16'hFF30, 8'h00, 1'b0, 2);
      chk("after_rst_io", rdata, 8'hC3);
      repeat (3) @(negedge clk);
      chk("sb_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
